// File: rtl/product_accumulator.sv
// Frame accumulator for unsigned 32-bit products: sums beats into an ACC_W-bit
// saturating accumulator and hands each closed frame to a one-deep result register.
module product_accumulator #(
    parameter int ACC_W     = 40,
    parameter int FRAME_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_product,
    input  logic             in_last,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_sat,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    localparam logic [7:0] FRAME_MAX_C = 8'(FRAME_MAX);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             sat;

    logic             vld_p0;
    logic             close_p0;
    logic [ACC_W:0]   sum_wide_p0;
    logic [ACC_W-1:0] sum_p0;
    logic [7:0]       cnt_p0;
    logic             sat_p0;

    function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] s);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic sat_ovf(input logic [ACC_W:0] s);
        return s[ACC_W];
    endfunction

    // Stage 0: beat arithmetic; IDLE contributes an empty partial frame
    always_comb begin
        vld_p0      = in_valid && !acc_clear;
        sum_wide_p0 = {1'b0, (state == ACCUM) ? acc : {ACC_W{1'b0}}}
                    + {{(ACC_W-31){1'b0}}, in_product};
        sum_p0      = sat_sum(sum_wide_p0);
        sat_p0      = ((state == ACCUM) && sat) || sat_ovf(sum_wide_p0);
        cnt_p0      = ((state == ACCUM) ? cnt : 8'd0) + 8'd1;
        close_p0    = vld_p0 && (in_last || (cnt_p0 == FRAME_MAX_C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc_clear) begin
            state_nxt = IDLE;
        end else if (vld_p0) begin
            state_nxt = close_p0 ? IDLE : ACCUM;
        end
    end

    always_comb begin
        busy = (state == ACCUM);
    end

    // Stage 1: partial-frame state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (acc_clear || close_p0) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (vld_p0) begin
            acc <= sum_p0;
            cnt <= cnt_p0;
            sat <= sat_p0;
        end
    end

    // Result register: a fresh load always wins over a same-edge handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (close_p0) begin
                out_valid <= 1'b1;
                out_sum   <= sum_p0;
                out_count <= cnt_p0;
                out_sat   <= sat_p0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (acc_clear) begin
                overrun <= 1'b0;
            end else if (close_p0 && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized scoreboard bench for product_accumulator across three parameter sets
// (default, narrow 34-bit accumulator, FRAME_MAX=4).
module tb_product_accumulator;

    typedef struct {
        longint sum;
        int     cnt;
        bit     sat;
    } res_t;

    localparam int ACCW [3] = '{40, 34, 48};
    localparam int FMAX [3] = '{255, 255, 4};
    localparam longint BIG = 64'd4294836225;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_product;
    logic        in_last;
    logic        acc_clear;
    logic        out_ready;

    logic        ov0, ov1, ov2;
    logic [39:0] sum0;
    logic [33:0] sum1;
    logic [47:0] sum2;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic        sat0, sat1, sat2;
    logic        ovr0, ovr1, ovr2;
    logic        busy0, busy1, busy2;

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    longint m_acc [3];
    int     m_cnt [3];
    bit     m_sat [3];
    bit     m_vld [3];
    bit     m_ovr [3];
    bit     m_busy [3];
    res_t   q0[$], q1[$], q2[$];

    product_accumulator #(.ACC_W(40), .FRAME_MAX(255)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .acc_clear(acc_clear), .out_valid(ov0), .out_ready(out_ready),
        .out_sum(sum0), .out_count(cnt0), .out_sat(sat0), .overrun(ovr0), .busy(busy0));

    product_accumulator #(.ACC_W(34), .FRAME_MAX(255)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .acc_clear(acc_clear), .out_valid(ov1), .out_ready(out_ready),
        .out_sum(sum1), .out_count(cnt1), .out_sat(sat1), .overrun(ovr1), .busy(busy1));

    product_accumulator #(.ACC_W(48), .FRAME_MAX(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_product(in_product),
        .in_last(in_last), .acc_clear(acc_clear), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(sum2), .out_count(cnt2), .out_sat(sat2), .overrun(ovr2), .busy(busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        int n;
        case (i)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        return n;
    endfunction

    task automatic q_push(input int i, input res_t r);
        case (i)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    task automatic q_drop_back(input int i);
        case (i)
            0:       void'(q0.pop_back());
            1:       void'(q1.pop_back());
            default: void'(q2.pop_back());
        endcase
    endtask

    function automatic res_t q_pop(input int i);
        res_t e;
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    task automatic model_clear(input int i);
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
        m_vld[i] = 0; m_ovr[i] = 0; m_busy[i] = 0;
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Reference behaviour for one clock edge of instance i
    task automatic model_edge(input int i, input bit v, input longint p,
                              input bit l, input bit c, input bit r);
        longint mx;
        longint s;
        int     n;
        bit     st;
        bit     load;
        res_t   e;
        mx   = (longint'(1) << ACCW[i]) - 1;
        load = 0;
        if (c) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_ovr[i] = 0; m_busy[i] = 0;
        end else if (v) begin
            s  = m_acc[i] + p;
            n  = m_cnt[i] + 1;
            st = m_sat[i];
            if (s > mx) begin
                s  = mx;
                st = 1;
            end
            if (l || n == FMAX[i]) begin
                load = 1;
                if (m_vld[i] && !r) begin
                    q_drop_back(i);
                    m_ovr[i] = 1;
                end
                e.sum = s; e.cnt = n; e.sat = st;
                q_push(i, e);
                m_vld[i] = 1;
                m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_busy[i] = 0;
            end else begin
                m_acc[i] = s; m_cnt[i] = n; m_sat[i] = st; m_busy[i] = 1;
            end
        end
        if (!load && m_vld[i] && r) m_vld[i] = 0;
    endtask

    task automatic step(input bit v, input longint p, input bit l, input bit c, input bit r);
        in_valid   = v;
        in_product = p[31:0];
        in_last    = l;
        acc_clear  = c;
        out_ready  = r;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, v, p, l, c, r);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_product = '0; in_last = 0; acc_clear = 0; out_ready = 0;
        rst_n = 0;
        #1;
        for (int i = 0; i < 3; i++) model_clear(i);
        chk("rst_valid", {ov0, ov1, ov2}, 0);
        chk("rst_sum0", longint'(sum0), 0);
        chk("rst_sum1", longint'(sum1), 0);
        chk("rst_sum2", longint'(sum2), 0);
        chk("rst_cnt", {cnt0, cnt1, cnt2}, 0);
        chk("rst_sat", {sat0, sat1, sat2}, 0);
        chk("rst_overrun", {ovr0, ovr1, ovr2}, 0);
        chk("rst_busy", {busy0, busy1, busy2}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic mon(input int i, input bit v, input longint s, input int c,
                       input bit st, input bit ov, input bit b);
        res_t e;
        chk($sformatf("i%0d_out_valid", i), v, m_vld[i]);
        chk($sformatf("i%0d_overrun", i), ov, m_ovr[i]);
        chk($sformatf("i%0d_busy", i), b, m_busy[i]);
        if (m_vld[i] && out_ready) begin
            if (qsize(i) == 0) begin
                chk($sformatf("i%0d_sb_nonempty", i), 0, 1);
            end else begin
                e = q_pop(i);
                chk($sformatf("i%0d_out_sum", i), s, e.sum);
                chk($sformatf("i%0d_out_count", i), c, e.cnt);
                chk($sformatf("i%0d_out_sat", i), st, e.sat);
            end
        end
    endtask

    // Scoreboard monitor: compares on the half-cycle ahead of each handshake edge
    always @(negedge clk) begin
        if (rst_n && !done) begin
            mon(0, ov0, longint'(sum0), int'(cnt0), sat0, ovr0, busy0);
            mon(1, ov1, longint'(sum1), int'(cnt1), sat1, ovr1, busy1);
            mon(2, ov2, longint'(sum2), int'(cnt2), sat2, ovr2, busy2);
        end
    end

    initial begin
        logic [31:0] r32;
        longint      p;
        int          sel;

        do_reset();
        step(0, 0, 0, 0, 1);

        step(1, 21, 0, 0, 1);
        step(1, 108, 0, 0, 1);
        step(1, 400, 1, 0, 1);
        chk("three_beat_valid", ov0, 1);
        chk("three_beat_sum", longint'(sum0), 529);
        chk("three_beat_count", cnt0, 3);
        chk("three_beat_sat", sat0, 0);
        step(0, 0, 0, 0, 1);
        chk("three_beat_valid_drop", ov0, 0);

        step(1, BIG, 1, 0, 1);
        chk("single_beat_sum", longint'(sum0), BIG);
        chk("single_beat_count", cnt0, 1);
        step(1, 5, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 7, 1, 0, 1);
        chk("bubble_sum", longint'(sum0), 12);
        chk("bubble_count", cnt0, 2);
        step(0, 0, 0, 0, 1);

        for (int k = 0; k < 5; k++) step(1, BIG, (k == 4), 0, 1);
        chk("narrow_sat_sum", longint'(sum1), 64'd17179869183);
        chk("narrow_sat_flag", sat1, 1);
        chk("narrow_sat_count", cnt1, 5);
        chk("wide_nosat_flag", sat0, 0);
        step(0, 0, 0, 0, 1);

        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0);
        chk("overwrite_sum", longint'(sum0), 3);
        chk("overwrite_count", cnt0, 1);
        chk("overwrite_flag", ovr0, 1);
        step(0, 0, 0, 1, 0);
        chk("clear_overrun", ovr0, 0);
        chk("clear_keeps_sum", longint'(sum0), 3);
        chk("clear_keeps_valid", ov0, 1);
        step(0, 0, 0, 0, 1);

        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 1);
        chk("fmax_valid", ov2, 1);
        chk("fmax_sum", longint'(sum2), 4);
        chk("fmax_count", cnt2, 4);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("fmax_continue_busy", busy2, 1);
        step(1, 1, 1, 0, 1);
        chk("fmax_tail_count", cnt2, 3);
        chk("fmax_tail_sum", longint'(sum2), 3);
        chk("long_frame_count", cnt0, 7);
        step(0, 0, 0, 0, 1);

        step(1, 10, 0, 0, 1);
        step(1, 20, 0, 0, 1);
        do_reset();
        step(1, 5, 1, 0, 1);
        chk("post_reset_sum", longint'(sum0), 5);
        chk("post_reset_count", cnt0, 1);
        step(0, 0, 0, 0, 1);

        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 3);
                r32 = $urandom();
                if (sel == 0)      p = BIG;
                else if (sel == 1) p = longint'({32'd0, r32});
                else               p = longint'($urandom_range(0, 1000));
                step($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
            end
        end

        repeat (4) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) chk($sformatf("i%0d_sb_drained", i), qsize(i), 0);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: ACC_W, 40, accumulator and sum width; legal range 33..48.
REQ-002 Parameter: FRAME_MAX, 255, maximum beats per frame; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  product beat present; no backpressure, so every valid beat is accepted.
REQ-006 Port: in_product  input  32  unsigned product from the upstream 4-stage 16x16 multiplier.
REQ-007 Port: in_last  input  1  beat closes the current frame; ignored when in_valid=0.
REQ-008 Port: acc_clear  input  1  synchronous abort of the partial frame.
REQ-009 Port: out_valid  output  1  result register holds an unconsumed frame sum.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: out_sum  output  ACC_W  frame sum.
REQ-012 Port: out_count  output  8  beats in the frame.
REQ-013 Port: out_sat  output  1  frame sum saturated.
REQ-014 Port: overrun  output  1  sticky flag: an unconsumed result was overwritten.
REQ-015 Port: busy  output  1  high when the FSM is in ACCUM.

Function
REQ-016 The FSM SHALL have two states: IDLE (no partial sum) and ACCUM (partial sum held).
- IDLE -> ACCUM: valid beat that does not close the frame.
- ACCUM -> IDLE: closing beat or acc_clear.
REQ-017 A beat SHALL close the frame when in_last=1 or when it is beat number FRAME_MAX.
REQ-018 Accepted beat: acc_next = acc + zero-extended in_product, with acc taken as 0 in IDLE.
REQ-019 If acc_next exceeds 2^ACC_W-1, the block SHALL clamp the sum to 2^ACC_W-1 and set a frame-sat bit; once set, the bit SHALL stay set until the frame closes.
REQ-020 On a closing beat at edge N, the block SHALL:
- load out_sum, out_count and out_sat at edge N;
- assert out_valid after edge N (1-cycle latency from the last beat);
- zero the accumulator, count and sat bit;
- enter IDLE.
REQ-021 A single-beat frame (IDLE, in_last=1) SHALL give out_sum=in_product and out_count=1.
REQ-022 out_valid SHALL stay high, with out_sum, out_count and out_sat stable, until an edge where out_ready=1 and no new result loads; out_valid then falls.
REQ-023 If a result loads on the same edge as an out_ready handshake, the new result SHALL replace the old one, out_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-024 If a result loads while out_valid=1 and out_ready=0, the new result SHALL overwrite the old one and overrun SHALL be set.
REQ-025 acc_clear=1 SHALL:
- discard any beat presented in that cycle;
- zero the accumulator, count and sat bit;
- enter IDLE;
- clear overrun.
acc_clear SHALL NOT alter out_valid, out_sum, out_count or out_sat, and SHALL take precedence over in_valid.
REQ-026 in_valid=0 cycles inside a frame SHALL hold the accumulator and count unchanged (bubbles are legal).

Reset
REQ-027 While rst_n=0, all of the following SHALL be forced immediately, regardless of clk:
- out_valid=0, out_sum=0, out_count=0, out_sat=0;
- overrun=0, busy=0;
- accumulator=0, count=0, sat bit=0;
- FSM=IDLE.
REQ-028 A reset asserted mid-frame SHALL discard the partial sum; the first valid beat after release SHALL start a new frame.

Verification
REQ-029 Beats 21, 108, 400 (last on the third), out_ready=1 -> one cycle after the third beat: out_valid=1, out_sum=529, out_count=3, out_sat=0; out_valid=0 the next cycle.
REQ-030 Single beat 4294836225 with last -> out_sum=4294836225, out_count=1; then 2 bubble cycles inside a 2-beat frame 5,7 -> out_sum=12, out_count=2.
REQ-031 ACC_W=34, five beats of 4294836225 (last on the fifth) -> out_sum=17179869183, out_sat=1, out_count=5.
REQ-032 Frame 1,2 (last) with out_ready=0 held, then frame 3 (last) -> out_sum=3, out_count=1, overrun=1; acc_clear pulse -> overrun=0, out_sum still 3.
REQ-033 FRAME_MAX=4, six beats of 1 with in_last=0 -> a result with out_sum=4, out_count=4; the partial frame continues with count 2.
REQ-034 Beats 10, 20, then rst_n low for 1 cycle, then beat 5 with last -> out_sum=5, out_count=1.
